// File: rtl/lt24_pixel_arbiter.sv
// lt24_pixel_arbiter: shares the LT24 pixel-write port between the board
// renderer (A) and the timer/status renderer (B). Whole bursts are granted
// round-robin, burst length is capped at MAX_BURST, and the winning beat is
// registered before it reaches the LT24 driver.
module lt24_pixel_arbiter #(
  parameter int MAX_BURST = 64
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        reqA_valid,
  input  logic [7:0]  reqA_x,
  input  logic [8:0]  reqA_y,
  input  logic [15:0] reqA_data,
  input  logic        reqA_last,
  output logic        reqA_ready,
  input  logic        reqB_valid,
  input  logic [7:0]  reqB_x,
  input  logic [8:0]  reqB_y,
  input  logic [15:0] reqB_data,
  input  logic        reqB_last,
  output logic        reqB_ready,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  // Owner encodings are one-hot so the grant output is the state itself.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            ptrB_q, ptrB_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cntInc;
  logic            pixelWrite_q, pixelWrite_d;
  logic [7:0]      xAddr_q, xAddr_d;
  logic [8:0]      yAddr_q, yAddr_d;
  logic [15:0]     pixelData_q, pixelData_d;
  logic            slotFree;
  logic            acceptA, acceptB, accept;
  logic            beatLast;
  logic            burstEnd;

  // Next-state, handshake and output-register load decisions.
  always_comb begin
    state_d      = state_q;
    ptrB_d       = ptrB_q;
    cnt_d        = cnt_q;
    pixelWrite_d = pixelWrite_q;
    xAddr_d      = xAddr_q;
    yAddr_d      = yAddr_q;
    pixelData_d  = pixelData_q;

    slotFree   = !pixelWrite_q || pixelReady;
    reqA_ready = (state_q == OWN_A) && slotFree;
    reqB_ready = (state_q == OWN_B) && slotFree;
    acceptA    = reqA_valid && reqA_ready;
    acceptB    = reqB_valid && reqB_ready;
    accept     = acceptA || acceptB;
    beatLast   = acceptA ? reqA_last : reqB_last;
    cntInc     = cnt_q + 1'b1;
    burstEnd   = accept && (beatLast || (cntInc == CW'(MAX_BURST)));

    case (state_q)
      IDLE: begin
        if (reqA_valid && reqB_valid) begin
          state_d = ptrB_q ? OWN_B : OWN_A;
        end else if (reqA_valid) begin
          state_d = OWN_A;
        end else if (reqB_valid) begin
          state_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (burstEnd) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptrB_d  = (state_q == OWN_A);
        end else if (accept) begin
          cnt_d = cntInc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      pixelWrite_d = 1'b1;
      xAddr_d      = acceptA ? reqA_x    : reqB_x;
      yAddr_d      = acceptA ? reqA_y    : reqB_y;
      pixelData_d  = acceptA ? reqA_data : reqB_data;
    end else if (pixelReady) begin
      pixelWrite_d = 1'b0;
    end
  end

  // State, pointer, burst counter and output register.
  always_ff @(posedge clock or negedge globalReset) begin
    if (!globalReset) begin
      state_q      <= IDLE;
      ptrB_q       <= 1'b0;
      cnt_q        <= '0;
      pixelWrite_q <= 1'b0;
      xAddr_q      <= '0;
      yAddr_q      <= '0;
      pixelData_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptrB_q       <= ptrB_d;
      cnt_q        <= cnt_d;
      pixelWrite_q <= pixelWrite_d;
      xAddr_q      <= xAddr_d;
      yAddr_q      <= yAddr_d;
      pixelData_q  <= pixelData_d;
    end
  end

  assign grant      = state_q;
  assign pixelWrite = pixelWrite_q;
  assign xAddr      = xAddr_q;
  assign yAddr      = yAddr_q;
  assign pixelData  = pixelData_q;
  assign busy       = (state_q != IDLE) || pixelWrite_q;

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// tb_lt24_pixel_arbiter: directed and randomized checks of the pixel
// arbiter against a beat-queue reference model kept in the bench.
module tb_lt24_pixel_arbiter;

  localparam int MAXB = 4;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clock;
  logic        globalReset;
  logic        reqA_valid, reqA_last, reqA_ready;
  logic [7:0]  reqA_x;
  logic [8:0]  reqA_y;
  logic [15:0] reqA_data;
  logic        reqB_valid, reqB_last, reqB_ready;
  logic [7:0]  reqB_x;
  logic [8:0]  reqB_y;
  logic [15:0] reqB_data;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic [1:0]  grant;
  logic        busy;

  lt24_pixel_arbiter #(.MAX_BURST(MAXB)) dut (
    .clock(clock), .globalReset(globalReset),
    .reqA_valid(reqA_valid), .reqA_x(reqA_x), .reqA_y(reqA_y),
    .reqA_data(reqA_data), .reqA_last(reqA_last), .reqA_ready(reqA_ready),
    .reqB_valid(reqB_valid), .reqB_x(reqB_x), .reqB_y(reqB_y),
    .reqB_data(reqB_data), .reqB_last(reqB_last), .reqB_ready(reqB_ready),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .grant(grant), .busy(busy)
  );

  // Free-running system clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Source queues, reference-model state and scoreboard.
  beat_t      qA[$];
  beat_t      qB[$];
  beat_t      expOut[$];
  logic [7:0] xLog[$];
  logic [7:0] expLog[$];
  bit         gateA, gateB;
  int         mOwner;
  int         mCnt;
  int         mPref;
  bit         mOutValid;
  beat_t      mOut;
  int         nChecks = 0;
  int         nFails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mOwner    = 0;
    mCnt      = 0;
    mPref     = 1;
    mOutValid = 1'b0;
    mOut      = '0;
    expOut.delete();
  endtask

  task automatic applyStimulus();
    reqA_valid = gateA && (qA.size() > 0);
    reqB_valid = gateB && (qB.size() > 0);
    if (qA.size() > 0) {reqA_x, reqA_y, reqA_data, reqA_last} = qA[0];
    else {reqA_x, reqA_y, reqA_data, reqA_last} = '0;
    if (qB.size() > 0) {reqB_x, reqB_y, reqB_data, reqB_last} = qB[0];
    else {reqB_x, reqB_y, reqB_data, reqB_last} = '0;
  endtask

  task automatic checkCycle();
    logic [1:0] eGrant;
    logic       eRdyA, eRdyB;
    beat_t      e;
    eGrant = (mOwner == 1) ? 2'b01 : (mOwner == 2) ? 2'b10 : 2'b00;
    eRdyA  = (mOwner == 1) && (!mOutValid || pixelReady);
    eRdyB  = (mOwner == 2) && (!mOutValid || pixelReady);
    checkOutput("cycle",
      {25'd0, grant, reqA_ready, reqB_ready, pixelWrite, busy, xAddr, yAddr, pixelData},
      {25'd0, eGrant, eRdyA, eRdyB, mOutValid, (mOwner != 0) || mOutValid,
       mOut.x, mOut.y, mOut.data});
    if (globalReset && pixelWrite && pixelReady) begin
      if (expOut.size() == 0) begin
        checkOutput("sbUnexpected", 64'd1, 64'd0);
      end else begin
        e = expOut.pop_front();
        checkOutput("sbBeat", {31'd0, xAddr, yAddr, pixelData}, {31'd0, e.x, e.y, e.data});
      end
      xLog.push_back(xAddr);
    end
  endtask

  task automatic modelStep();
    bit    accept;
    int    owner;
    beat_t b;
    owner  = mOwner;
    accept = (owner == 1 && reqA_valid && (!mOutValid || pixelReady)) ||
             (owner == 2 && reqB_valid && (!mOutValid || pixelReady));
    if (owner == 0) begin
      if (reqA_valid && reqB_valid) mOwner = mPref;
      else if (reqA_valid)          mOwner = 1;
      else if (reqB_valid)          mOwner = 2;
    end else if (accept) begin
      if (owner == 1) b = qA.pop_front();
      else            b = qB.pop_front();
      mCnt++;
      expOut.push_back(b);
      mOut = b;
      if (b.last || mCnt == MAXB) begin
        mOwner = 0;
        mCnt   = 0;
        mPref  = (owner == 1) ? 2 : 1;
      end
    end
    if (accept)          mOutValid = 1'b1;
    else if (pixelReady) mOutValid = 1'b0;
  endtask

  task automatic tick();
    applyStimulus();
    #1;
    checkCycle();
    if (globalReset) modelStep();
    @(negedge clock);
  endtask

  task automatic runCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pushBeat(input bit toB, input logic [7:0] x, input logic [8:0] y,
                          input logic [15:0] d, input bit last);
    beat_t b;
    b = {x, y, d, last};
    if (toB) qB.push_back(b);
    else     qA.push_back(b);
  endtask

  task automatic enterReset();
    globalReset = 1'b0;
    resetModel();
    qA.delete();
    qB.delete();
    runCycles(2);
    xLog.delete();
  endtask

  task automatic checkLog(input string tag);
    int n;
    checkOutput({tag, "Len"}, 64'(xLog.size()), 64'(expLog.size()));
    n = (xLog.size() < expLog.size()) ? xLog.size() : expLog.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "X"}, 64'(xLog[i]), 64'(expLog[i]));
    xLog.delete();
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    globalReset = 1'b0;
    gateA = 1'b1;
    gateB = 1'b1;
    pixelReady = 1'b1;
    resetModel();
    applyStimulus();
    @(negedge clock);

    $display("[TB] reset with inputs high, then A burst and B burst");
    enterReset();
    for (int i = 0; i < 3; i++) pushBeat(0, 8'(10 + i), 9'd5, 16'hF800, i == 2);
    for (int i = 0; i < 2; i++) pushBeat(1, 8'(100 + i), 9'd7, 16'h07E0, i == 1);
    runCycles(3);
    globalReset = 1'b1;
    runCycles(15);
    expLog = '{8'd10, 8'd11, 8'd12, 8'd100, 8'd101};
    checkLog("order1");

    $display("[TB] alternating bursts of two");
    enterReset();
    for (int i = 0; i < 6; i++) pushBeat(0, 8'(20 + i), 9'(i), 16'h1234, i[0]);
    for (int i = 0; i < 4; i++) pushBeat(1, 8'(120 + i), 9'(i), 16'h4321, i[0]);
    globalReset = 1'b1;
    runCycles(30);
    expLog = '{8'd20, 8'd21, 8'd120, 8'd121, 8'd22, 8'd23, 8'd122, 8'd123, 8'd24, 8'd25};
    checkLog("order2");

    $display("[TB] burst cap with A streaming and B waiting");
    enterReset();
    for (int i = 0; i < 10; i++) pushBeat(0, 8'(30 + i), 9'd300, 16'hAAAA, 1'b0);
    for (int i = 0; i < 3; i++) pushBeat(1, 8'(130 + i), 9'd301, 16'h5555, 1'b1);
    globalReset = 1'b1;
    runCycles(40);
    expLog = '{8'd30, 8'd31, 8'd32, 8'd33, 8'd130, 8'd34, 8'd35, 8'd36, 8'd37,
               8'd131, 8'd38, 8'd39};
    checkLog("capOrder");

    $display("[TB] output stall for five cycles");
    enterReset();
    for (int i = 0; i < 8; i++) pushBeat(0, 8'(50 + i), 9'(200 + i), 16'(16'hC000 + i), i == 7);
    globalReset = 1'b1;
    runCycles(3);
    pixelReady = 1'b0;
    runCycles(5);
    pixelReady = 1'b1;
    runCycles(12);
    expLog = '{8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57};
    checkLog("stallOrder");

    $display("[TB] asynchronous reset in the middle of a B burst");
    enterReset();
    gateA = 1'b0;
    for (int i = 0; i < 4; i++) pushBeat(1, 8'(140 + i), 9'd9, 16'hFFFF, i == 3);
    globalReset = 1'b1;
    runCycles(3);
    checkOutput("preRstWrite", 64'(pixelWrite), 64'd1);
    #2;
    globalReset = 1'b0;
    #1;
    checkOutput("asyncRst",
      {25'd0, grant, reqA_ready, reqB_ready, pixelWrite, busy, xAddr, yAddr, pixelData}, 64'd0);
    @(negedge clock);
    enterReset();
    gateA = 1'b1;
    pushBeat(0, 8'd60, 9'd1, 16'h0001, 1'b0);
    pushBeat(0, 8'd61, 9'd1, 16'h0002, 1'b1);
    pushBeat(1, 8'd150, 9'd2, 16'h0003, 1'b0);
    pushBeat(1, 8'd151, 9'd2, 16'h0004, 1'b1);
    globalReset = 1'b1;
    runCycles(15);
    expLog = '{8'd60, 8'd61, 8'd150, 8'd151};
    checkLog("postRst");

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 700; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        if ((s == 0 ? qA.size() : qB.size()) < 3) begin
          int len;
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++)
            pushBeat(s == 1, 8'($urandom), 9'($urandom), 16'($urandom), k == len - 1);
        end
      end
      gateA = ($urandom_range(0, 3) != 0);
      gateB = ($urandom_range(0, 3) != 0);
      pixelReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    gateA = 1'b1;
    gateB = 1'b1;
    pixelReady = 1'b1;
    runCycles(80);
    checkOutput("drainA", 64'(qA.size()), 64'd0);
    checkOutput("drainB", 64'(qB.size()), 64'd0);
    checkOutput("drainOut", 64'(expOut.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/lt24_pixel_arbiter.md
# lt24_pixel_arbiter

Shares the single LT24 display-driver pixel-write port between two render sources inside the chess engine: requester A (board/piece renderer) and requester B (timer/status renderer). Grants whole bursts round-robin, caps burst length so neither source starves the other, and registers the winning pixel beat before it reaches the LT24 driver. Sits between the renderers and the LT24 display driver.

## Interface
- MAX_BURST, default 64, maximum beats per grant (legal 1..255)
- clock  input  1  system clock
- globalReset  input  1  asynchronous, active-low reset
- reqA_valid  input  1  A presents a pixel beat
- reqA_x  input  8  A pixel column (0..239)
- reqA_y  input  9  A pixel row (0..319)
- reqA_data  input  16  A RGB565 colour
- reqA_last  input  1  beat is final of A burst
- reqA_ready  output  1  A beat accepted this cycle when high with reqA_valid
- reqB_valid, reqB_x, reqB_y, reqB_data, reqB_last, reqB_ready  same as A, for B
- xAddr  output  8  registered column to LT24 driver
- yAddr  output  9  registered row
- pixelData  output  16  registered colour
- pixelWrite  output  1  output register holds a valid beat
- pixelReady  input  1  LT24 driver consumes beat when high with pixelWrite
- grant  output  2  one-hot current owner (bit0 = A, bit1 = B), 0 in IDLE
- busy  output  1  state not IDLE or pixelWrite high

## Operation
- States: IDLE, OWN_A, OWN_B. grant decodes state directly.
- IDLE: if only one valid, go to its OWN state; if both valid, go to OWN of requester named by priority pointer; if none, stay.
- Priority pointer: 1 bit, reset to A; on every burst end it points to the other requester.
- In OWN_x: reqx_ready = !pixelWrite | pixelReady; other requester's ready = 0. In IDLE both readies 0.
- Accepted beat (valid & ready) loads x/y/data into output register and sets pixelWrite; burst counter increments.
- Output register: pixelWrite clears on pixelReady unless a new beat loads same cycle; register contents held stable while pixelWrite & !pixelReady.
- Burst end: accepted beat with last = 1, or accepted beat making count = MAX_BURST. Next state IDLE, counter cleared, pointer toggled.
- Owner deasserting valid mid-burst without last: grant is held (no timeout); stays in OWN_x.
- Counter width clog2(MAX_BURST+1); never exceeds MAX_BURST.
- x/y passed unchecked; range is renderer responsibility.

## Timing
- Reset (asynchronous assert, synchronous release to clock): state IDLE, grant 0, pointer A, counter 0, pixelWrite 0, xAddr 0, yAddr 0, pixelData 0, reqA_ready 0, reqB_ready 0, busy 0.
- Arbitration: valid seen in IDLE at cycle n -> grant at n+1 -> first ready at n+1 (pixelWrite is 0 or draining).
- Beat accepted at cycle n -> pixelWrite/xAddr/yAddr/pixelData at n+1.
- Full throughput: one beat per cycle while pixelReady held high.
- Burst end at cycle n -> IDLE at n+1 (one dead cycle, grant 0) -> next owner at n+2.
- Burst end and pending output beat: last beat drains normally; IDLE does not wait for drain.
- Reset mid-burst: pending output beat discarded, no partial recovery.

## Test plan
- Reset with all inputs high -> every output 0, grant 0 until release; first rising edge after release with reqA_valid -> grant = 01.
- A sends 3 beats (x = 10,11,12, y = 5, data = F800, last on third), pixelReady = 1 -> pixelWrite high 3 consecutive cycles with x 10,11,12 in order; grant 0 one cycle after third acceptance.
- A and B both valid from reset, each bursts of 2 with last -> order A,A,B,B,A,A; exactly one IDLE cycle between bursts; pointer alternates.
- MAX_BURST = 4, A streams 10 beats without last, B valid throughout -> A 4 beats, B burst, A 4 beats, B, A 2 remaining; no beat lost or duplicated.
- pixelReady low 5 cycles with pixelWrite high -> xAddr/yAddr/pixelData stable, owner ready 0; after pixelReady rises, stream resumes with no gap or loss.
- globalReset asserted mid-burst of B at beat 2 -> outputs 0 immediately (asynchronous); after release both valid -> A granted first.
